s2p_deser_n: RTL and testbench
==============================

// Module: s2p_deser_n
// PURPOSE
//  Parametrised serial-to-parallel deserialiser for the FFT datapath; successor to the fixed 4-lane converter.
//  Gathers LANES consecutive enabled samples into one parallel word and pulses out_valid once per group.
//  Owns its own group counter, so no external counter is needed.
//  A sync input realigns group boundaries at frame start, and mid-group realignment is flagged.
// PARAMETERS
//  WORDLENGTH  16   bits per sample
//  LANES       4    samples per output group; power of 2, range 2..64
//  CNT_W       $clog2(LANES)  group counter width (derived; do not override)
// PORTS
//  clk        in   1                  system clock, rising edge
//  rst        in   1                  asynchronous reset, active-low
//  enable     in   1                  data_in is a valid sample this cycle
//  sync       in   1                  qualified by enable: this sample is lane-group position 0
//  data_in    in   WORDLENGTH         serial sample
//  data_out   out  LANES*WORDLENGTH   parallel group; lane i = data_out[i*WORDLENGTH +: WORDLENGTH]
//  out_valid  out  1                  one-cycle pulse: data_out holds a new group
//  sync_err   out  1                  one-cycle pulse: sync arrived with a partial group pending
//  grp_cnt    out  CNT_W              samples held in current partial group (debug/status)
// BEHAVIOUR
//  Reset (rst=0, async):
//   - shift register, data_out, grp_cnt, out_valid and sync_err all clear to 0.
//  Shift: on enable=1, sh[0] <= data_in and sh[k] <= sh[k-1]; with enable=0 all state holds.
//  Counter: on enable, grp_cnt increments and wraps LANES-1 -> 0.
//  Group complete: enable=1 and grp_cnt==LANES-1 (with sync=0) completes a group.
//   - Next edge: data_out lane k <= sample that arrived k samples before the last one.
//     Lane 0 = newest, lane LANES-1 = oldest.
//   - out_valid=1 for exactly that cycle.
//   - Latency: last sample in -> out_valid high 1 clk later.
//  data_out holds its value between groups, until the next completion.
//  sync: enable=1 and sync=1 treats data_in as sample 0 of a new group (grp_cnt <= 1, shift proceeds).
//   - If grp_cnt != 0 at that moment: the partial group is discarded (no out_valid), sync_err pulses 1 clk.
//   - If grp_cnt == 0: normal; no error.
//   - sync with enable=0 is ignored.
//   - sync on a group-completing cycle (grp_cnt==LANES-1): sync wins. No group is emitted, sync_err pulses.
//  Back-to-back groups: enable held high gives an out_valid pulse every LANES cycles, with no bubbles.
//  Gaps in enable only stretch a group; samples never drop.
//  rst asserted mid-group: the partial group is lost and the next enabled sample is sample 0.
// CONFIGURATION
//  Macro S2P_BITREV_EN.
//   - Defined: output lane order is bit-reversed over CNT_W bits (lane i <- position bitrev(i)).
//     The FFT input stage uses this to get natural order.
//   - Undefined: plain ordering as above.
//  Either way, latency and handshake are unchanged.
// STRUCTURE
//  Shared package fft_pkg:
//   - WORDLENGTH default, LANES default.
//   - bitrev function on CNT_W bits.
//   - lane slice macro/constant for data_out indexing.
//  One natural sub-module: s2p_lane_reg (WORDLENGTH-wide enabled register).
//   - Generate-instantiated LANES times for the shift chain.
//   - Output holding register and counter/sync control stay in s2p_deser_n.
// TESTING
//  1) LANES=4, enable=1, data_in 1,2,3,4 -> 1 clk after "4": out_valid=1, lanes0..3 = 4,3,2,1, grp_cnt=0.
//  2) Stream 1..12 with enable=1 -> out_valid at clk 5, 9, 13 (exactly every 4). 3rd group lanes = 12,11,10,9.
//  3) Samples 1,2, then sync=1 with 7, then 8,9,10 -> sync_err pulse after 7, no group {2,1}, next group lanes = 10,9,8,7.
//  4) enable toggled 1,0,1,0... over 1..4 -> data_out held between groups, one out_valid after "4", no sample loss.
//  5) rst low after 3 samples, release, feed 5,6,7,8 -> all outputs 0 during reset, then group 8,7,6,5 with no err.
//  6) S2P_BITREV_EN defined, LANES=4, feed 1..4 -> lanes0..3 = 4,2,3,1. LANES=8 matches the bitrev model.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: default widths, bit-reversal and lane-slice helpers.
package fft_pkg;

    localparam int WORDLENGTH_DEF = 16;
    localparam int LANES_DEF      = 4;

    // Reverses the low `bits` bits of v; used at elaboration to build lane permutations.
    function automatic int bitrev(input int v, input int bits);
        int r;
        r = 0;
        for (int b = 0; b < 32; b++) begin
            if (b < bits) r = (r << 1) | ((v >> b) & 1);
        end
        return r;
    endfunction

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/s2p_deser_n_if.sv
// Deserialiser bus: serial sample side in, parallel group and status out.
interface s2p_deser_n_if
    import fft_pkg::*;
#(
    parameter int WORDLENGTH = WORDLENGTH_DEF,
    parameter int LANES      = LANES_DEF
);
    localparam int CNT_W = $clog2(LANES);

    // enable qualifies data_in and sync; out_valid and sync_err are single-cycle pulses.
    logic                        enable;
    logic                        sync;
    logic [WORDLENGTH-1:0]       data_in;
    logic [LANES*WORDLENGTH-1:0] data_out;
    logic                        out_valid;
    logic                        sync_err;
    logic [CNT_W-1:0]            grp_cnt;

    modport master (
        output enable, sync, data_in,
        input  data_out, out_valid, sync_err, grp_cnt
    );

    modport slave (
        input  enable, sync, data_in,
        output data_out, out_valid, sync_err, grp_cnt
    );

endinterface

// File: rtl/s2p_lane_reg.sv
// One stage of the deserialiser shift chain: WORDLENGTH-wide register with load enable.
module s2p_lane_reg #(
    parameter int WORDLENGTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [WORDLENGTH-1:0] d,
    output logic [WORDLENGTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/s2p_deser_n.sv
// Serial-to-parallel deserialiser: LANES enabled samples per output group, sync realignment.
// Macro S2P_BITREV_EN selects bit-reversed lane order on data_out.
module s2p_deser_n
    import fft_pkg::*;
#(
    parameter int WORDLENGTH = WORDLENGTH_DEF,
    parameter int LANES      = LANES_DEF
) (
    input  logic         clk,
    input  logic         rst,
    s2p_deser_n_if.slave bus
);

    localparam int CNT_W = $clog2(LANES);

    logic [WORDLENGTH-1:0]       sh  [LANES];
    logic [WORDLENGTH-1:0]       nxt [LANES];
    logic [LANES*WORDLENGTH-1:0] grp_word;
    logic [LANES*WORDLENGTH-1:0] data_q;
    logic [CNT_W-1:0]            cnt_q;
    logic                        valid_q;
    logic                        err_q;
    logic                        sync_hit;
    logic                        grp_done;
    logic                        sync_mid;

    // nxt[k] is what position k holds after this edge, so a completed group includes data_in.
    for (genvar k = 0; k < LANES; k++) begin : g_chain
        if (k == 0) begin : g_head
            assign nxt[k] = bus.data_in;
        end else begin : g_tail
            assign nxt[k] = sh[k-1];
        end

        s2p_lane_reg #(.WORDLENGTH(WORDLENGTH)) u_lane (
            .clk (clk),
            .rst (rst),
            .en  (bus.enable),
            .d   (nxt[k]),
            .q   (sh[k])
        );
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane_map
`ifdef S2P_BITREV_EN
        localparam int SRC = bitrev(i, CNT_W);
`else
        localparam int SRC = i;
`endif
        assign grp_word[lane_lsb(i, WORDLENGTH) +: WORDLENGTH] = nxt[SRC];
    end

    // sync takes priority over group completion, discarding any partial group.
    assign sync_hit = bus.enable & bus.sync;
    assign grp_done = bus.enable & ~bus.sync & (cnt_q == CNT_W'(LANES - 1));
    assign sync_mid = sync_hit & (cnt_q != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= grp_done;
            err_q   <= sync_mid;
            if (sync_hit)        cnt_q <= CNT_W'(1);
            else if (bus.enable) cnt_q <= cnt_q + 1'b1;
            if (grp_done)        data_q <= grp_word;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.sync_err  = err_q;
    assign bus.grp_cnt   = cnt_q;

endmodule

// File: tb/tb_s2p_deser_n.sv
// Bench for s2p_deser_n: directed scenarios plus a random stream on LANES=4 and LANES=8 instances.
module tb_s2p_deser_n;
  import fft_pkg::*;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         en  = 1'b0;
  logic         sy  = 1'b0;
  logic [W-1:0] din = '0;

  s2p_deser_n_if #(.WORDLENGTH(W), .LANES(4)) bus4 ();
  s2p_deser_n_if #(.WORDLENGTH(W), .LANES(8)) bus8 ();

  assign bus4.enable  = en;
  assign bus4.sync    = sy;
  assign bus4.data_in = din;
  assign bus8.enable  = en;
  assign bus8.sync    = sy;
  assign bus8.data_in = din;

  s2p_deser_n #(.WORDLENGTH(W), .LANES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  s2p_deser_n #(.WORDLENGTH(W), .LANES(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  // ---------------- reference model ----------------
  logic [W-1:0]   hist[$];
  int             n_part[2];
  int             lanes_of[2] = '{4, 8};
  logic           exp_v[2];
  logic           exp_e[2];
  logic [8*W-1:0] exp_d[2];
  logic [4*W-1:0] exp_q[$];
  logic [4*W-1:0] got_grp;
  int             errors = 0;
  int             checks = 0;

  function automatic int rev_bits(input int v, input int bits);
    int r = 0;
    for (int b = 0; b < bits; b++) r = r * 2 + ((v >> b) % 2);
    return r;
  endfunction

  // Which arrival position (0 = newest) lands in lane i.
  function automatic int lane_pos(input int i, input int lanes);
`ifdef S2P_BITREV_EN
    return rev_bits(i, $clog2(lanes));
`else
    return i;
`endif
  endfunction

  function automatic logic [8*W-1:0] group_of(input int lanes);
    logic [8*W-1:0] g = '0;
    for (int i = 0; i < lanes; i++)
      g[i*W +: W] = hist[hist.size() - 1 - lane_pos(i, lanes)];
    return g;
  endfunction

  // Expected 4-lane word from the four newest samples, newest first.
  function automatic logic [4*W-1:0] exp4(input logic [W-1:0] p0, p1, p2, p3);
`ifdef S2P_BITREV_EN
    return {p3, p1, p2, p0};
`else
    return {p3, p2, p1, p0};
`endif
  endfunction

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    for (int j = 0; j < 2; j++) begin
      n_part[j] = 0; exp_v[j] = 1'b0; exp_e[j] = 1'b0; exp_d[j] = '0;
    end
  endtask

  task automatic model_update(input logic e, input logic s, input logic [W-1:0] d);
    for (int j = 0; j < 2; j++) begin
      exp_v[j] = 1'b0; exp_e[j] = 1'b0;
    end
    if (e) begin
      hist.push_back(d);
      if (hist.size() > 16) void'(hist.pop_front());
      for (int j = 0; j < 2; j++) begin
        if (s) begin
          exp_e[j]  = (n_part[j] != 0);
          n_part[j] = 1;
        end else begin
          n_part[j]++;
          if (n_part[j] == lanes_of[j]) begin
            exp_v[j]  = 1'b1;
            n_part[j] = 0;
            exp_d[j]  = group_of(lanes_of[j]);
            if (j == 0) exp_q.push_back(exp_d[0][4*W-1:0]);
          end
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic e, input logic s, input logic [W-1:0] d);
    en = e; sy = s; din = d;
    model_update(e, s, d);
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus4.data_out !== '0) begin errors++; $display("FAIL reset_data4 got=%0h exp=0", bus4.data_out); end
    checks++; if (bus4.out_valid !== 1'b0 || bus4.sync_err !== 1'b0) begin errors++; $display("FAIL reset_flags4 got v=%b e=%b exp 0 0", bus4.out_valid, bus4.sync_err); end
    checks++; if (bus4.grp_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt4 got=%0d exp=0", bus4.grp_cnt); end
    checks++; if (bus8.data_out !== '0 || bus8.grp_cnt !== 3'd0) begin errors++; $display("FAIL reset_dut8 got d=%0h c=%0d exp 0 0", bus8.data_out, bus8.grp_cnt); end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b0, W'(i));
      checks++; if (bus4.out_valid !== (i == 4)) begin errors++; $display("FAIL basic_valid i=%0d got=%b exp=%b", i, bus4.out_valid, (i == 4)); end
      checks++; if (bus4.grp_cnt !== 2'(i % 4)) begin errors++; $display("FAIL basic_cnt i=%0d got=%0d exp=%0d", i, bus4.grp_cnt, i % 4); end
    end
    checks++; if (bus4.data_out !== exp4(4, 3, 2, 1)) begin errors++; $display("FAIL basic_data got=%0h exp=%0h", bus4.data_out, exp4(4, 3, 2, 1)); end
    step(1'b0, 1'b0, 16'hdead);
    checks++; if (bus4.out_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse got=%b exp=0", bus4.out_valid); end
    checks++; if (bus4.data_out !== exp4(4, 3, 2, 1)) begin errors++; $display("FAIL basic_hold got=%0h exp=%0h", bus4.data_out, exp4(4, 3, 2, 1)); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b0, W'(i));
      if (bus4.out_valid === 1'b1) pulses++;
      checks++; if (bus4.out_valid !== (i % 4 == 0)) begin errors++; $display("FAIL b2b_valid i=%0d got=%b exp=%b", i, bus4.out_valid, (i % 4 == 0)); end
    end
    checks++; if (pulses != 3) begin errors++; $display("FAIL b2b_pulses got=%0d exp=3", pulses); end
    checks++; if (bus4.data_out !== exp4(12, 11, 10, 9)) begin errors++; $display("FAIL b2b_data got=%0h exp=%0h", bus4.data_out, exp4(12, 11, 10, 9)); end
  endtask

  task automatic test_sync();
    step(1'b1, 1'b0, 16'd1);
    step(1'b1, 1'b0, 16'd2);
    step(1'b1, 1'b1, 16'd7);
    checks++; if (bus4.sync_err !== 1'b1 || bus4.out_valid !== 1'b0) begin errors++; $display("FAIL sync_mid got e=%b v=%b exp 1 0", bus4.sync_err, bus4.out_valid); end
    checks++; if (bus4.grp_cnt !== 2'd1) begin errors++; $display("FAIL sync_cnt got=%0d exp=1", bus4.grp_cnt); end
    step(1'b0, 1'b1, 16'd99);
    checks++; if (bus4.sync_err !== 1'b0 || bus4.grp_cnt !== 2'd1) begin errors++; $display("FAIL sync_noen got e=%b c=%0d exp 0 1", bus4.sync_err, bus4.grp_cnt); end
    for (int i = 8; i <= 10; i++) begin
      step(1'b1, 1'b0, W'(i));
      checks++; if (bus4.sync_err !== 1'b0 || bus4.out_valid !== (i == 10)) begin errors++; $display("FAIL sync_run i=%0d got e=%b v=%b", i, bus4.sync_err, bus4.out_valid); end
    end
    checks++; if (bus4.data_out !== exp4(10, 9, 8, 7)) begin errors++; $display("FAIL sync_data got=%0h exp=%0h", bus4.data_out, exp4(10, 9, 8, 7)); end
    // sync on an aligned boundary is clean; sync on the completing sample discards the group
    step(1'b1, 1'b1, 16'd1);
    checks++; if (bus4.sync_err !== 1'b0) begin errors++; $display("FAIL sync_aligned got=%b exp=0", bus4.sync_err); end
    step(1'b1, 1'b0, 16'd2);
    step(1'b1, 1'b0, 16'd3);
    step(1'b1, 1'b1, 16'd5);
    checks++; if (bus4.sync_err !== 1'b1 || bus4.out_valid !== 1'b0 || bus4.grp_cnt !== 2'd1) begin errors++; $display("FAIL sync_last got e=%b v=%b c=%0d exp 1 0 1", bus4.sync_err, bus4.out_valid, bus4.grp_cnt); end
    for (int i = 6; i <= 8; i++) step(1'b1, 1'b0, W'(i));
    checks++; if (bus4.out_valid !== 1'b1 || bus4.data_out !== exp4(8, 7, 6, 5)) begin errors++; $display("FAIL sync_last_grp got v=%b d=%0h exp 1 %0h", bus4.out_valid, bus4.data_out, exp4(8, 7, 6, 5)); end
  endtask

  task automatic test_gaps();
    logic [4*W-1:0] held;
    held = exp4(8, 7, 6, 5);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b0, W'(i + 20));
      checks++; if (bus4.out_valid !== (i == 4)) begin errors++; $display("FAIL gap_valid i=%0d got=%b exp=%b", i, bus4.out_valid, (i == 4)); end
      if (i == 4) held = exp4(24, 23, 22, 21);
      step(1'b0, 1'b0, W'($urandom));
      checks++; if (bus4.out_valid !== 1'b0 || bus4.grp_cnt !== 2'(i % 4)) begin errors++; $display("FAIL gap_idle i=%0d got v=%b c=%0d", i, bus4.out_valid, bus4.grp_cnt); end
      checks++; if (bus4.data_out !== held) begin errors++; $display("FAIL gap_hold i=%0d got=%0h exp=%0h", i, bus4.data_out, held); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, W'(i));
    en = 1'b0; sy = 1'b0;
    rst = 1'b0;
    model_reset();
    #1;
    checks++; if (bus4.data_out !== '0 || bus4.grp_cnt !== 2'd0 || bus4.out_valid !== 1'b0 || bus4.sync_err !== 1'b0) begin errors++; $display("FAIL rstmid_async got d=%0h c=%0d", bus4.data_out, bus4.grp_cnt); end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 5; i <= 8; i++) begin
      step(1'b1, 1'b0, W'(i));
      checks++; if (bus4.sync_err !== 1'b0 || bus4.out_valid !== (i == 8)) begin errors++; $display("FAIL rstmid_run i=%0d got e=%b v=%b", i, bus4.sync_err, bus4.out_valid); end
    end
    checks++; if (bus4.data_out !== exp4(8, 7, 6, 5)) begin errors++; $display("FAIL rstmid_data got=%0h exp=%0h", bus4.data_out, exp4(8, 7, 6, 5)); end
    exp_q.delete();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, W'($urandom));
      checks++; if (bus4.out_valid !== exp_v[0] || bus4.sync_err !== exp_e[0]) begin errors++; $display("FAIL rnd_flags4 n=%0d got v=%b e=%b exp v=%b e=%b", n, bus4.out_valid, bus4.sync_err, exp_v[0], exp_e[0]); end
      checks++; if (bus4.grp_cnt !== 2'(n_part[0])) begin errors++; $display("FAIL rnd_cnt4 n=%0d got=%0d exp=%0d", n, bus4.grp_cnt, n_part[0]); end
      if (bus4.out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rnd_sb4 n=%0d got unexpected group %0h", n, bus4.data_out); end
        else begin
          got_grp = exp_q.pop_front();
          if (bus4.data_out !== got_grp) begin errors++; $display("FAIL rnd_sb4 n=%0d got=%0h exp=%0h", n, bus4.data_out, got_grp); end
        end
      end
      checks++; if (bus4.data_out !== exp_d[0][4*W-1:0]) begin errors++; $display("FAIL rnd_data4 n=%0d got=%0h exp=%0h", n, bus4.data_out, exp_d[0][4*W-1:0]); end
      checks++; if (bus8.out_valid !== exp_v[1] || bus8.sync_err !== exp_e[1]) begin errors++; $display("FAIL rnd_flags8 n=%0d got v=%b e=%b exp v=%b e=%b", n, bus8.out_valid, bus8.sync_err, exp_v[1], exp_e[1]); end
      checks++; if (bus8.grp_cnt !== 3'(n_part[1])) begin errors++; $display("FAIL rnd_cnt8 n=%0d got=%0d exp=%0d", n, bus8.grp_cnt, n_part[1]); end
      checks++; if (bus8.data_out !== exp_d[1]) begin errors++; $display("FAIL rnd_data8 n=%0d got=%0h exp=%0h", n, bus8.data_out, exp_d[1]); end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_sb4_left got=%0d exp=0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_sync();
    test_gaps();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
